// File: rtl/dm_sba.sv
// rtl/dm_sba.sv - System Bus Access engine: sbcs/sbaddress0/sbdata0 registers driving a single-beat 32-bit bus master
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   dmi_req_i, dmi_wr_i     DMI access strobe (one cycle per access) and direction
//   dmi_addr_i, dmi_wdata_i DM register address (0x38 sbcs, 0x39 sbaddress0, 0x3C sbdata0) and write data
//   dmi_rdata_o             combinational read data for dmi_addr_i, 0 when unmapped
//   bus_req_o, bus_we_o     transaction request (held until ack/err/timeout) and direction
//   bus_addr_o, bus_wdata_o word-aligned address and write data
//   bus_rdata_i             read data, valid with bus_ack_i
//   bus_ack_i, bus_err_i    transaction completed / failed
module dm_sba #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dmi_req_i,
    input  logic        dmi_wr_i,
    input  logic [6:0]  dmi_addr_i,
    input  logic [31:0] dmi_wdata_i,
    output logic [31:0] dmi_rdata_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    input  logic        bus_err_i
);

    localparam logic [6:0] ADDR_SBCS  = 7'h38;
    localparam logic [6:0] ADDR_SBADR = 7'h39;
    localparam logic [6:0] ADDR_SBDAT = 7'h3C;

    localparam logic [2:0] ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_BUS     = 3'd2;
    localparam logic [2:0] ERR_ALIGN   = 3'd3;
    localparam logic [2:0] ERR_SIZE    = 3'd4;

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e      state_q, state_d;
    logic [31:0] sbaddr_q, sbaddr_d;
    logic [31:0] sbdata_q, sbdata_d;
    logic        readonaddr_q, readonaddr_d;
    logic [2:0]  access_q, access_d;
    logic        autoinc_q, autoinc_d;
    logic        readondata_q, readondata_d;
    logic        busyerr_q, busyerr_d;
    logic [2:0]  sberror_q, sberror_d;
    logic        inc_q, inc_d;            // autoincrement latched for the in-flight access
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic        busy;
    logic        cs_wr, addr_wr, data_wr, data_rd;
    logic        trig, blocked;
    logic [31:0] addr_eff;
    logic [31:0] sbcs_val;

    assign busy    = (state_q == S_BUSY);
    assign cs_wr   = dmi_req_i &  dmi_wr_i & (dmi_addr_i == ADDR_SBCS);
    assign addr_wr = dmi_req_i &  dmi_wr_i & (dmi_addr_i == ADDR_SBADR);
    assign data_wr = dmi_req_i &  dmi_wr_i & (dmi_addr_i == ADDR_SBDAT);
    assign data_rd = dmi_req_i & ~dmi_wr_i & (dmi_addr_i == ADDR_SBDAT);

    assign trig    = (addr_wr & readonaddr_q) | data_wr | (data_rd & readondata_q);
    assign blocked = busyerr_q | (sberror_q != 3'd0);
    // A trigger from an sbaddress0 write uses the address being written this cycle.
    assign addr_eff = addr_wr ? dmi_wdata_i : sbaddr_q;

    assign sbcs_val = {3'd1, 6'd0, busyerr_q, busy, readonaddr_q, access_q, autoinc_q,
                       readondata_q, sberror_q, 7'd32, 5'b00100};

    always_comb begin
        dmi_rdata_o = 32'd0;
        case (dmi_addr_i)
            ADDR_SBCS:  dmi_rdata_o = sbcs_val;
            ADDR_SBADR: dmi_rdata_o = sbaddr_q;
            ADDR_SBDAT: dmi_rdata_o = sbdata_q;
            default:    dmi_rdata_o = 32'd0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        sbaddr_d     = sbaddr_q;
        sbdata_d     = sbdata_q;
        readonaddr_d = readonaddr_q;
        access_d     = access_q;
        autoinc_d    = autoinc_q;
        readondata_d = readondata_q;
        busyerr_d    = busyerr_q;
        sberror_d    = sberror_q;
        inc_d        = inc_q;
        cnt_d        = cnt_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;

        // Config and W1C first; error sets further down override a same-cycle clear.
        if (cs_wr) begin
            readonaddr_d = dmi_wdata_i[20];
            access_d     = dmi_wdata_i[19:17];
            autoinc_d    = dmi_wdata_i[16];
            readondata_d = dmi_wdata_i[15];
            if (dmi_wdata_i[22]) begin
                busyerr_d = 1'b0;
            end
            sberror_d = sberror_q & ~dmi_wdata_i[14:12];
        end

        if (busy) begin
            if (addr_wr | data_wr | data_rd) begin
                busyerr_d = 1'b1;
            end
            if (bus_err_i) begin
                sberror_d = ERR_BUS;
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end else if (bus_ack_i) begin
                if (!bus_we_q) begin
                    sbdata_d = bus_rdata_i;
                end
                if (inc_q) begin
                    sbaddr_d = sbaddr_q + 32'd4;
                end
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end else if (cnt_q == TIMEOUT) begin
                sberror_d = ERR_TIMEOUT;
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            if (addr_wr) begin
                sbaddr_d = dmi_wdata_i;
            end
            if (data_wr) begin
                sbdata_d = dmi_wdata_i;
            end
            if (trig && !blocked) begin
                if (access_q != 3'd2) begin
                    sberror_d = ERR_SIZE;
                end else if (addr_eff[1:0] != 2'b00) begin
                    sberror_d = ERR_ALIGN;
                end else begin
                    state_d     = S_BUSY;
                    cnt_d       = 8'd0;
                    inc_d       = autoinc_q;
                    bus_req_d   = 1'b1;
                    bus_we_d    = data_wr;
                    bus_addr_d  = addr_eff;
                    bus_wdata_d = data_wr ? dmi_wdata_i : sbdata_q;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            sbaddr_q     <= 32'd0;
            sbdata_q     <= 32'd0;
            readonaddr_q <= 1'b0;
            access_q     <= 3'd2;
            autoinc_q    <= 1'b0;
            readondata_q <= 1'b0;
            busyerr_q    <= 1'b0;
            sberror_q    <= 3'd0;
            inc_q        <= 1'b0;
            cnt_q        <= 8'd0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'd0;
            bus_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            sbaddr_q     <= sbaddr_d;
            sbdata_q     <= sbdata_d;
            readonaddr_q <= readonaddr_d;
            access_q     <= access_d;
            autoinc_q    <= autoinc_d;
            readondata_q <= readondata_d;
            busyerr_q    <= busyerr_d;
            sberror_q    <= sberror_d;
            inc_q        <= inc_d;
            cnt_q        <= cnt_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule
